// File: rtl/shift_sequencer_pkg.sv
// Shared CPU package: ALU opcodes, shift sequencer state encoding and count helper.
// SHIFT_COUNT_MASK_EN restricts the effective shift count to count[4:0].
package shift_sequencer_pkg;

  typedef enum logic [3:0] {
    ALUOP_ADD         = 4'd0,
    ALUOP_SUB         = 4'd1,
    ALUOP_SHIFT_LEFT  = 4'd2,
    ALUOP_SHIFT_RIGHT = 4'd3
  } alu_op_t;

  typedef enum logic [1:0] {
    SEQ_IDLE,
    SEQ_SHIFT,
    SEQ_DONE
  } seq_state_t;

  localparam int unsigned DATA_W  = 16;
  localparam int unsigned COUNT_W = 8;

  function automatic logic [COUNT_W-1:0] effective_count(input logic [COUNT_W-1:0] count);
`ifdef SHIFT_COUNT_MASK_EN
    return count & 8'h1F;
`else
    return count;
`endif
  endfunction

endpackage

// File: rtl/shift_sequencer_if.sv
// Request/result handshake and ALU side-channel of the shift sequencer.
// master = execution unit side, slave = sequencer side.
interface shift_sequencer_if;
  import shift_sequencer_pkg::*;

  logic              start_valid;
  logic              start_ready;
  logic              dir;
  logic              word;
  logic [DATA_W-1:0] operand;
  logic [COUNT_W-1:0] count;

  alu_op_t           alu_op;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [DATA_W-1:0] alu_r;

  logic              done_valid;
  logic              done_ready;
  logic [DATA_W-1:0] result;
  logic              carry_out;
  logic              count_zero;

  modport master (
    output start_valid, dir, word, operand, count, done_ready, alu_r,
    input  start_ready, alu_op, alu_a, alu_b, done_valid, result, carry_out, count_zero
  );

  modport slave (
    input  start_valid, dir, word, operand, count, done_ready, alu_r,
    output start_ready, alu_op, alu_a, alu_b, done_valid, result, carry_out, count_zero
  );

endinterface

// File: rtl/shift_sequencer.sv
// Multi-cycle shifter that steps an external ALU one bit per cycle.
// Build option SHIFT_COUNT_MASK_EN limits the shift count to 0..31.
module shift_sequencer
  import shift_sequencer_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  shift_sequencer_if.slave   bus
);

  seq_state_t         state;
  logic [DATA_W-1:0]  working;
  logic [COUNT_W-1:0] remaining;
  logic [COUNT_W-1:0] eff;
  logic               dir_q;
  logic               word_q;
  logic               carry;
  logic               zero_q;
  logic [DATA_W-1:0]  next_working;
  logic               outgoing;

  assign eff = effective_count(bus.count);

  assign bus.start_ready = (state == SEQ_IDLE) && !reset;
  assign bus.done_valid  = (state == SEQ_DONE);
  assign bus.result      = working;
  assign bus.carry_out   = carry;
  assign bus.count_zero  = zero_q;
  assign bus.alu_b       = '0;

  always_comb begin
    bus.alu_op = ALUOP_ADD;
    bus.alu_a  = '0;
    if (state == SEQ_SHIFT) begin
      bus.alu_op = dir_q ? ALUOP_SHIFT_RIGHT : ALUOP_SHIFT_LEFT;
      bus.alu_a  = working;
    end
  end

  // Byte mode keeps the upper byte clear so bits never re-enter from above.
  always_comb begin
    next_working = word_q ? bus.alu_r : {8'h00, bus.alu_r[7:0]};
    outgoing     = dir_q ? working[0] : (word_q ? working[15] : working[7]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= SEQ_IDLE;
      working   <= '0;
      remaining <= '0;
      dir_q     <= 1'b0;
      word_q    <= 1'b0;
      carry     <= 1'b0;
      zero_q    <= 1'b0;
    end else begin
      case (state)
        SEQ_IDLE: begin
          if (bus.start_valid && bus.start_ready) begin
            working   <= bus.word ? bus.operand : {8'h00, bus.operand[7:0]};
            dir_q     <= bus.dir;
            word_q    <= bus.word;
            remaining <= eff;
            carry     <= 1'b0;
            if (eff == '0) begin
              zero_q <= 1'b1;
              state  <= SEQ_DONE;
            end else begin
              zero_q <= 1'b0;
              state  <= SEQ_SHIFT;
            end
          end
        end
        SEQ_SHIFT: begin
          working   <= next_working;
          carry     <= outgoing;
          remaining <= remaining - 1'b1;
          if (remaining == 8'd1) begin
            state <= SEQ_DONE;
          end
        end
        SEQ_DONE: begin
          if (bus.done_ready) begin
            state <= SEQ_IDLE;
          end
        end
        default: state <= SEQ_IDLE;
      endcase
    end
  end

endmodule

// File: doc/shift_sequencer.md
SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset: clk  input  1  rising-edge clock.
REQ-002 reset  input  1  synchronous active-high reset.
REQ-003 start_valid  input  1  shift request present.
REQ-004 start_ready  output  1  sequencer accepts a request this cycle.
REQ-005 dir  input  1  0 = left, 1 = right.
REQ-006 word  input  1  1 = 16-bit operand, 0 = 8-bit (low byte).
REQ-007 operand  input  16  value to shift.
REQ-008 count  input  8  requested shift count.
REQ-009 alu_op  output  4  opcode driven to the ALU.
REQ-010 alu_a  output  16  ALU A operand.
REQ-011 alu_b  output  16  ALU B operand, always 0.
REQ-012 alu_r  input  16  combinational ALU result for alu_op/alu_a this cycle.
REQ-013 done_valid  output  1  result available.
REQ-014 done_ready  input  1  consumer takes the result.
REQ-015 result  output  16  shifted value; upper byte 0 in byte mode.
REQ-016 carry_out  output  1  last bit shifted out.
REQ-017 count_zero  output  1  effective count was 0.

Function
REQ-018 The FSM SHALL have three states: IDLE, SHIFT and DONE.
REQ-019 start_ready SHALL be 1 only in IDLE with reset low.
REQ-020 On start_valid&&start_ready, the block SHALL latch the working value as operand, or {8'h00, operand[7:0]} when word=0, and latch dir, word and the effective count.
REQ-021 With effective count 0, the FSM SHALL go to DONE with result=working value, carry_out=0 and count_zero=1.
REQ-022 Otherwise it SHALL go to SHIFT with count_zero=0.
REQ-023 In SHIFT, each cycle SHALL drive alu_op=ALUOP_SHIFT_LEFT (dir=0) or ALUOP_SHIFT_RIGHT (dir=1), alu_a=working value and alu_b=0.
REQ-024 Each SHIFT cycle, the block SHALL register working <= alu_r, masked to [7:0] in byte mode, and decrement the remaining count.
REQ-025 Each SHIFT cycle, carry SHALL capture the outgoing bit: bit 15 (word, left), bit 7 (byte, left) or bit 0 (right).
REQ-026 When the remaining count is 1 at a SHIFT edge, the FSM SHALL transition to DONE.
REQ-027 Latency: for N>0, done_valid SHALL rise exactly N+1 cycles after the accept cycle.
REQ-028 Latency: for N=0, done_valid SHALL rise exactly 1 cycle after the accept cycle.
REQ-029 Outside SHIFT, alu_op SHALL be ALUOP_ADD and alu_a SHALL be 0.
REQ-030 In DONE, done_valid=1, and result, carry_out and count_zero SHALL be held stable until done_ready=1.
REQ-031 On done_valid&&done_ready, the FSM SHALL return to IDLE.
REQ-032 A new request SHALL NOT be accepted in that same cycle; the earliest accept is the next cycle.
REQ-033 start_valid SHALL be ignored in SHIFT and DONE.
REQ-034 Input changes after the accept cycle SHALL have no effect.
REQ-035 Counts greater than the operand width SHALL continue shifting, giving result 0 and carry 0 once all bits are exhausted.

Reset
REQ-036 Reset SHALL force state IDLE, result=0, carry_out=0, count_zero=0, done_valid=0, start_ready=0, working value=0 and remaining count=0.
REQ-037 Reset asserted in SHIFT or DONE SHALL abandon the operation with no done_valid pulse.
REQ-038 After reset deasserts, start_ready SHALL be 1 in the first cycle.

Configuration
REQ-039 With SHIFT_COUNT_MASK_EN defined, the effective count SHALL be count[4:0] (0..31).
REQ-040 Without SHIFT_COUNT_MASK_EN, the effective count SHALL be the full 8-bit count (0..255).

Structure
REQ-041 The AluOp encoding (ADD=0, SUB=1, SHIFT_LEFT=2, SHIFT_RIGHT=3) and the sequencer state enum SHALL live in the shared CPU package.
REQ-042 The block SHALL contain no sub-modules; the ALU is instantiated beside it by the execution unit, connected through alu_op, alu_a, alu_b and alu_r.

Verification
REQ-043 Word, left, operand 0x8001, count 1 -> done_valid 2 cycles after accept; result 0x0002; carry_out 1.
REQ-044 Byte, right, operand 0xFF81, count 2 -> result 0x0020; carry_out 0; carry was 1 after the first shift.
REQ-045 Count 0, operand 0x1234 -> done_valid 1 cycle after accept; result 0x1234; carry_out 0; count_zero 1.
REQ-046 Word, left, operand 0xFFFF, count 33 -> with the mask: result 0xFFFE, carry 1, latency 2; without the mask: result 0x0000, carry 0, latency 34.
REQ-047 done_ready held low 5 cycles in DONE -> result, carry_out and done_valid stable; start_ready 0; start_valid pulses ignored.
REQ-048 Reset pulsed on SHIFT cycle 3 of a count-10 shift -> no done_valid; next cycle start_ready 1; result 0; a subsequent count-1 request completes normally.
